// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round controller.
// Holds the FSM state set, latch-result record and LFSR seed/taps.
package tow_pkg;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_RELEASE = 3'd1;
   localparam state_t S_WAIT    = 3'd2;
   localparam state_t S_GO      = 3'd3;
   localparam state_t S_SCORE   = 3'd4;
   localparam state_t S_HOLD    = 3'd5;
   localparam state_t S_WIN     = 3'd6;

   // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int CNT_W = 8;

   typedef struct packed {
      logic push;
      logic tie;
      logic right;
   } lat_t;

endpackage

// File: rtl/tow_lfsr16.sv
// 16-bit Fibonacci LFSR; advances one step per enabled cycle, never all-zero.
// Latency: q is the register itself; no backpressure.
module tow_lfsr16
   import tow_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic [15:0] q
);

   logic [15:0] q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (enable) begin
         q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= LFSR_SEED;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/tow_round_ctrl.sv
// Tug-of-war round sequencer: random hold-off, GO cue, scoring, rope position and win detect.
// All outputs registered; latch results are sampled one cycle late; no backpressure.
module tow_round_ctrl
   import tow_pkg::*;
#(
   parameter int DLY_MIN     = 16,
   parameter int DLY_W       = 4,
   parameter int GO_TIMEOUT  = 64,
   parameter int RESULT_HOLD = 8,
   parameter int POS_W       = 4,
   parameter int WIN_POS     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pbl,
   input  logic             pbr,
   input  logic             push,
   input  logic             tie,
   input  logic             right,
   output logic             clear,
   output logic             go,
   output logic [POS_W-1:0] pos,
   output logic             round_done,
   output logic             false_start,
   output logic             winner_valid,
   output logic             winner_right
);

   localparam logic signed [POS_W:0] WIN_P = (POS_W+1)'(WIN_POS);
   localparam logic signed [POS_W:0] WIN_N = -WIN_P;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic signed [POS_W-1:0] pos_q, pos_d;
   lat_t                    lat_q, lat_d;
   logic                    clear_q, clear_d;
   logic                    go_q, go_d;
   logic                    round_done_q, round_done_d;
   logic                    false_start_q, false_start_d;
   logic                    winner_valid_q, winner_valid_d;
   logic                    winner_right_q, winner_right_d;

   logic [15:0]             lfsr;
   logic                    lfsr_unused;
   logic                    fs_hit;
   logic                    void_hit;
   logic signed [POS_W:0]   pos_ext, step, sum_norm, sum_fs;
   logic signed [POS_W-1:0] pos_norm, pos_fs;

   tow_lfsr16 u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .enable (1'b1),
      .q      (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:DLY_W];

   function automatic logic signed [POS_W-1:0] sat(input logic signed [POS_W:0] v);
      if (v > WIN_P) begin
         sat = WIN_P[POS_W-1:0];
      end else if (v < WIN_N) begin
         sat = WIN_N[POS_W-1:0];
      end else begin
         sat = v[POS_W-1:0];
      end
   endfunction

   // A false start moves the rope against the presser, hence the negated step.
   always_comb begin
      lat_d    = '{push: push, tie: tie, right: right};
      pos_ext  = {pos_q[POS_W-1], pos_q};
      step     = lat_q.right ? (POS_W+1)'(1) : (lat_q.tie ? '0 : '1);
      sum_norm = pos_ext + step;
      sum_fs   = pos_ext - step;
      pos_norm = sat(sum_norm);
      pos_fs   = sat(sum_fs);
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pos_d    = pos_q;
      fs_hit   = 1'b0;
      void_hit = 1'b0;
      unique case (state_q)
         S_IDLE, S_WIN: begin
            if (start) begin
               state_d = S_RELEASE;
               pos_d   = '0;
            end
         end
         S_RELEASE: begin
            if (!pbl && !pbr) begin
               state_d = S_WAIT;
               cnt_d   = CNT_W'(DLY_MIN) + CNT_W'(lfsr[DLY_W-1:0]);
            end
         end
         S_WAIT: begin
            if (lat_q.push) begin
               state_d = S_SCORE;
               pos_d   = pos_fs;
               fs_hit  = 1'b1;
            end else if (cnt_q == '0) begin
               state_d = S_GO;
               cnt_d   = CNT_W'(GO_TIMEOUT);
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GO: begin
            if (lat_q.push) begin
               state_d = S_SCORE;
               pos_d   = pos_norm;
            end else if (cnt_q == '0) begin
               state_d  = S_HOLD;
               cnt_d    = CNT_W'(RESULT_HOLD);
               void_hit = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_SCORE: begin
            if ((pos_q == WIN_P[POS_W-1:0]) || (pos_q == WIN_N[POS_W-1:0])) begin
               state_d = S_WIN;
            end else begin
               state_d = S_HOLD;
               cnt_d   = CNT_W'(RESULT_HOLD);
            end
         end
         S_HOLD: begin
            if (cnt_q == '0) begin
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_comb begin
      clear_d        = !((state_d == S_WAIT) || (state_d == S_GO));
      go_d           = (state_d == S_GO);
      round_done_d   = (state_d == S_SCORE) || void_hit;
      false_start_d  = fs_hit;
      winner_valid_d = (state_d == S_WIN);
      winner_right_d = (state_d == S_WIN) && !pos_d[POS_W-1] && (pos_d != '0);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         pos_q          <= '0;
         lat_q          <= '0;
         clear_q        <= 1'b1;
         go_q           <= 1'b0;
         round_done_q   <= 1'b0;
         false_start_q  <= 1'b0;
         winner_valid_q <= 1'b0;
         winner_right_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         pos_q          <= pos_d;
         lat_q          <= lat_d;
         clear_q        <= clear_d;
         go_q           <= go_d;
         round_done_q   <= round_done_d;
         false_start_q  <= false_start_d;
         winner_valid_q <= winner_valid_d;
         winner_right_q <= winner_right_d;
      end
   end

   assign clear        = clear_q;
   assign go           = go_q;
   assign pos          = pos_q;
   assign round_done   = round_done_q;
   assign false_start  = false_start_q;
   assign winner_valid = winner_valid_q;
   assign winner_right = winner_right_q;

endmodule
